// File: rtl/hd44780_bus_receiver.sv
// LCD-side HD44780 4-bit write-bus receiver: pin sync, E timing checks, nybble assembly, entry FIFO.
// Optional busy-flag model enabled with `define HD44780_BUSRX_BUSY_MODEL_EN.
module hd44780_bus_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int PWEH_MIN    = 22,
    parameter int TCYCE_MIN   = 48,
    parameter int COUNT_BITS  = 7,
    parameter int FIFO_ABITS  = 3
`ifdef HD44780_BUSRX_BUSY_MODEL_EN
    ,
    parameter int BUSY_LONG   = 144000,
    parameter int BUSY_SHORT  = 2544
`endif
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_e,
    input  logic       i_rs,
    input  logic [3:0] i_nybble,
    input  logic       i_ack,
    input  logic       i_clr_err,
    output logic [8:0] o_dat,
    output logic       o_valid,
    output logic       o_mode_4bit,
    output logic       o_err_pw,
    output logic       o_err_cycle,
    output logic       o_err_rs,
    output logic       o_overflow,
    output logic       o_busy,
    output logic       o_err_busy
);
    localparam int DEPTH = 1 << FIFO_ABITS;
    localparam logic [COUNT_BITS-1:0] PW_MIN_C  = COUNT_BITS'(PWEH_MIN);
    localparam logic [COUNT_BITS:0]   CYC_MIN_C = (COUNT_BITS + 1)'(TCYCE_MIN);
    localparam logic [FIFO_ABITS:0]   DEPTH_C   = (FIFO_ABITS + 1)'(DEPTH);

    typedef enum logic [1:0] {S_M8, S_H4_HI, S_H4_LO} state_t;

    logic [SYNC_STAGES-1:0] r_e_sync;
    logic [SYNC_STAGES-1:0] r_rs_sync;
    logic [3:0]             r_nyb_sync [SYNC_STAGES];
    logic                   r_e_d, r_rs_smp, r_have_rise;
    logic [3:0]             r_nyb_smp;
    logic [COUNT_BITS-1:0]  r_pw, r_cyc;
    logic                   w_e_s, w_rise, w_fall, w_pw_short, w_cyc_short;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_e_sync  <= '0;
            r_rs_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_nyb_sync[i] <= '0;
        end else begin
            r_e_sync      <= {r_e_sync[SYNC_STAGES-2:0], i_e};
            r_rs_sync     <= {r_rs_sync[SYNC_STAGES-2:0], i_rs};
            r_nyb_sync[0] <= i_nybble;
            for (int i = 1; i < SYNC_STAGES; i++) r_nyb_sync[i] <= r_nyb_sync[i-1];
        end
    end

    assign w_e_s  = r_e_sync[SYNC_STAGES-1];
    assign w_rise = w_e_s & ~r_e_d;
    assign w_fall = r_e_d & ~w_e_s;
    assign w_pw_short  = w_fall & (r_pw < PW_MIN_C);
    // cyc holds period-1 at a rise, so the +1 gives the true rise-to-rise period.
    assign w_cyc_short = w_rise & r_have_rise & (({1'b0, r_cyc} + (COUNT_BITS + 1)'(1)) < CYC_MIN_C);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_e_d       <= 1'b0;
            r_rs_smp    <= 1'b0;
            r_nyb_smp   <= '0;
            r_pw        <= '0;
            r_cyc       <= '0;
            r_have_rise <= 1'b0;
        end else begin
            r_e_d       <= w_e_s;
            r_have_rise <= r_have_rise | w_rise;
            if (w_e_s) begin
                r_rs_smp  <= r_rs_sync[SYNC_STAGES-1];
                r_nyb_smp <= r_nyb_sync[SYNC_STAGES-1];
            end
            if (w_rise)                    r_pw <= '0;
            else if (w_e_s && r_pw != '1)  r_pw <= r_pw + 1'b1;
            if (w_rise)                    r_cyc <= '0;
            else if (r_cyc != '1)          r_cyc <= r_cyc + 1'b1;
        end
    end

    // Assembler FSM, advanced only on E falling edges.
    state_t     r_state, w_state_next;
    logic       r_hi_rs, r_push;
    logic [3:0] r_hi_nyb;
    logic [8:0] r_push_dat, w_emit_dat;
    logic       w_emit, w_err_rs_set, w_store_hi;

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_dat   = '0;
        w_err_rs_set = 1'b0;
        w_store_hi   = 1'b0;
        if (w_fall) begin
            case (r_state)
                S_M8: begin
                    w_emit     = 1'b1;
                    w_emit_dat = {r_rs_smp, r_nyb_smp, 4'h0};
                    if (!r_rs_smp && r_nyb_smp == 4'h2) w_state_next = S_H4_HI;
                end
                S_H4_HI: begin
                    w_store_hi   = 1'b1;
                    w_state_next = S_H4_LO;
                end
                S_H4_LO: begin
                    w_emit       = 1'b1;
                    w_emit_dat   = {r_hi_rs, r_hi_nyb, r_nyb_smp};
                    w_err_rs_set = r_rs_smp != r_hi_rs;
                    w_state_next = (!r_hi_rs && r_hi_nyb == 4'h3) ? S_M8 : S_H4_HI;
                end
                default: w_state_next = S_M8;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= S_M8;
            r_hi_rs    <= 1'b0;
            r_hi_nyb   <= '0;
            r_push     <= 1'b0;
            r_push_dat <= '0;
        end else begin
            r_state    <= w_state_next;
            r_push     <= w_emit;
            r_push_dat <= w_emit_dat;
            if (w_store_hi) begin
                r_hi_rs  <= r_rs_smp;
                r_hi_nyb <= r_nyb_smp;
            end
        end
    end

    assign o_mode_4bit = (r_state != S_M8);

    // FIFO: count disambiguates full from empty since pointers wrap.
    logic [8:0]            r_mem [DEPTH];
    logic [FIFO_ABITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_ABITS:0]   r_count;
    logic                  w_full, w_pop, w_wr;

    assign w_full  = (r_count == DEPTH_C);
    assign o_valid = (r_count != '0);
    assign w_pop   = i_ack & o_valid;
    assign w_wr    = r_push & (~w_full | w_pop);
    assign o_dat   = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge CLK_I) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_dat;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_ABITS'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_ABITS'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    logic r_err_pw, r_err_cycle, r_err_rs, r_overflow;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_err_pw    <= 1'b0;
            r_err_cycle <= 1'b0;
            r_err_rs    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_err_pw    <= w_pw_short   | (r_err_pw    & ~i_clr_err);
            r_err_cycle <= w_cyc_short  | (r_err_cycle & ~i_clr_err);
            r_err_rs    <= w_err_rs_set | (r_err_rs    & ~i_clr_err);
            r_overflow  <= (r_push & w_full & ~w_pop) | (r_overflow & ~i_clr_err);
        end
    end

    assign o_err_pw    = r_err_pw;
    assign o_err_cycle = r_err_cycle;
    assign o_err_rs    = r_err_rs;
    assign o_overflow  = r_overflow;

`ifdef HD44780_BUSRX_BUSY_MODEL_EN
    localparam int BUSY_BITS = $clog2(BUSY_LONG + 1);
    logic [BUSY_BITS-1:0] r_busy_cnt;
    logic                 r_err_busy, w_busy_long;

    // Clear display, return home and its alias take the long execution time.
    assign w_busy_long = ~r_push_dat[8] &
                         (r_push_dat[7:0] == 8'h01 || r_push_dat[7:0] == 8'h02 || r_push_dat[7:0] == 8'h03);
    assign o_busy      = (r_busy_cnt != '0);
    assign o_err_busy  = r_err_busy;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_busy_cnt <= '0;
            r_err_busy <= 1'b0;
        end else begin
            if (r_push)      r_busy_cnt <= w_busy_long ? BUSY_BITS'(BUSY_LONG) : BUSY_BITS'(BUSY_SHORT);
            else if (o_busy) r_busy_cnt <= r_busy_cnt - 1'b1;
            r_err_busy <= (w_fall & o_busy) | (r_err_busy & ~i_clr_err);
        end
    end
`else
    assign o_busy     = 1'b0;
    assign o_err_busy = 1'b0;
`endif

endmodule

// File: tb/tb_hd44780_bus_receiver.sv
// Bench for hd44780_bus_receiver: table of nybble writes plus hand-written timing, overflow and reset sequences.
module tb_hd44780_bus_receiver;
    localparam int SYNC_STAGES = 2;

    logic       CLK_I = 1'b0;
    logic       RST_I, i_e, i_rs, i_ack, i_clr_err;
    logic [3:0] i_nybble;
    logic [8:0] o_dat;
    logic       o_valid, o_mode_4bit, o_err_pw, o_err_cycle, o_err_rs, o_overflow, o_busy, o_err_busy;

    hd44780_bus_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .i_e(i_e), .i_rs(i_rs), .i_nybble(i_nybble),
        .i_ack(i_ack), .i_clr_err(i_clr_err), .o_dat(o_dat), .o_valid(o_valid),
        .o_mode_4bit(o_mode_4bit), .o_err_pw(o_err_pw), .o_err_cycle(o_err_cycle),
        .o_err_rs(o_err_rs), .o_overflow(o_overflow), .o_busy(o_busy), .o_err_busy(o_err_busy)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic       rs;
        logic [3:0] nyb;
        logic       emit;
        logic [8:0] dat;
        logic [3:0] flags;  // {mode_4bit, err_rs, err_pw, err_cycle} after the write
    } vec_t;

    vec_t       vecs [10];
    logic [8:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    // One E pulse: high for 'high' clock edges, rise-to-rise period of 'cycle' edges.
    task automatic send(input logic rs, input logic [3:0] nyb, input int high, input int cycle);
        i_rs = rs;
        i_nybble = nyb;
        i_e = 1'b1;
        tick(high);
        i_e = 1'b0;
        tick(cycle - high);
    endtask

    // Pop and compare every expected entry, with a bounded wait for o_valid.
    task automatic drain();
        while (exp_q.size() != 0) begin
            logic [8:0] exp_dat;
            exp_dat = exp_q.pop_front();
            @(negedge CLK_I);
            for (int k = 0; k < 300 && !o_valid; k++) @(negedge CLK_I);
            chk("fifo_valid", 32'(o_valid), 32'd1);
            chk("fifo_dat", 32'(o_dat), 32'(exp_dat));
            i_ack = 1'b1;
            tick(1);
            i_ack = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 4'h3, 1'b1, 9'h030, 4'b0000};
        vecs[1] = '{1'b0, 4'h3, 1'b1, 9'h030, 4'b0000};
        vecs[2] = '{1'b0, 4'h3, 1'b1, 9'h030, 4'b0000};
        vecs[3] = '{1'b0, 4'h2, 1'b1, 9'h020, 4'b1000};
        vecs[4] = '{1'b1, 4'h4, 1'b0, 9'h000, 4'b1000};
        vecs[5] = '{1'b1, 4'h8, 1'b1, 9'h148, 4'b1000};
        vecs[6] = '{1'b0, 4'h2, 1'b0, 9'h000, 4'b1000};
        vecs[7] = '{1'b1, 4'h8, 1'b1, 9'h028, 4'b1100};
        vecs[8] = '{1'b0, 4'h3, 1'b0, 9'h000, 4'b1100};
        vecs[9] = '{1'b0, 4'h0, 1'b1, 9'h030, 4'b0100};

        RST_I = 1'b1; i_e = 1'b0; i_rs = 1'b0; i_nybble = 4'h0; i_ack = 1'b0; i_clr_err = 1'b0;
        tick(3);
        RST_I = 1'b0;
        tick(2);
        @(negedge CLK_I);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_dat", 32'(o_dat), 32'd0);
        chk("reset_flags", 32'({o_mode_4bit, o_err_pw, o_err_cycle, o_err_rs, o_overflow, o_busy, o_err_busy}), 32'd0);

        // Init sequence, 4-bit data and RS-mismatch / mode-return rows.
        for (int v = 0; v < 10; v++) begin
            send(vecs[v].rs, vecs[v].nyb, 30, 100);
            if (vecs[v].emit) exp_q.push_back(vecs[v].dat);
            @(negedge CLK_I);
            chk($sformatf("vec%0d_flags", v), 32'({o_mode_4bit, o_err_rs, o_err_pw, o_err_cycle}), 32'(vecs[v].flags));
        end
        drain();
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        @(negedge CLK_I);
        chk("clr_err_rs", 32'(o_err_rs), 32'd0);

        // o_valid latency from the first edge that samples E low.
        send(1'b0, 4'h2, 30, 100);
        exp_q.push_back(9'h020);
        drain();
        send(1'b1, 4'h4, 30, 100);
        i_rs = 1'b1; i_nybble = 4'h8; i_e = 1'b1;
        tick(30);
        i_e = 1'b0;
        tick(SYNC_STAGES + 1);
        @(negedge CLK_I);
        chk("latency_before", 32'(o_valid), 32'd0);
        tick(1);
        @(negedge CLK_I);
        chk("latency_at", 32'(o_valid), 32'd1);
        tick(60);
        exp_q.push_back(9'h148);
        drain();

        // Short E-high, then a short rise-to-rise period.
        send(1'b1, 4'h6, 10, 30);
        @(negedge CLK_I);
        chk("err_pw_set", 32'({o_err_pw, o_err_cycle}), 32'b10);
        send(1'b1, 4'h1, 25, 100);
        exp_q.push_back(9'h161);
        @(negedge CLK_I);
        chk("err_cycle_set", 32'({o_err_pw, o_err_cycle}), 32'b11);
        drain();
        i_clr_err = 1'b1;
        tick(1);
        i_clr_err = 1'b0;
        @(negedge CLK_I);
        chk("timing_clr", 32'({o_err_pw, o_err_cycle}), 32'b00);

        // Back to 8-bit mode, then overflow the 8-entry FIFO.
        send(1'b0, 4'h3, 30, 100);
        send(1'b0, 4'h0, 30, 100);
        exp_q.push_back(9'h030);
        drain();
        @(negedge CLK_I);
        chk("mode_8bit", 32'(o_mode_4bit), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            send(1'b1, 4'(k), 30, 100);
            if (k <= 8) exp_q.push_back({1'b1, 4'(k), 4'h0});
            if (k == 8) begin
                @(negedge CLK_I);
                chk("overflow_at_full", 32'(o_overflow), 32'd0);
            end
        end
        @(negedge CLK_I);
        chk("overflow_set", 32'(o_overflow), 32'd1);
        drain();
        @(negedge CLK_I);
        chk("ninth_absent", 32'(o_valid), 32'd0);
        i_ack = 1'b1;
        tick(1);
        i_ack = 1'b0;
        @(negedge CLK_I);
        chk("ack_empty", 32'(o_valid), 32'd0);

        // Reset after a hi nybble discards it and returns to 8-bit mode.
        send(1'b0, 4'h2, 30, 100);
        exp_q.push_back(9'h020);
        drain();
        send(1'b1, 4'h7, 30, 100);
        @(negedge CLK_I);
        chk("mid_byte_mode", 32'(o_mode_4bit), 32'd1);
        RST_I = 1'b1;
        tick(2);
        RST_I = 1'b0;
        @(negedge CLK_I);
        chk("reset2_mode_ovf", 32'({o_mode_4bit, o_overflow}), 32'b00);
        send(1'b1, 4'h5, 30, 100);
        exp_q.push_back(9'h150);
        drain();
        @(negedge CLK_I);
        chk("reset2_flags", 32'({o_mode_4bit, o_err_pw, o_err_cycle, o_err_rs, o_overflow}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
